uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx_if.sv | 15 +
 rtl/uart_rx.sv | 113 +++++++++++
 tb/tb_uart_rx.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// uart_rx_if: received-byte stream from uart_rx to its consumer.
//   data          byte at the head of the receive buffer
//   data_valid    head is valid (buffer non-empty)
//   data_ready    consumer takes the head when high with data_valid
//   framing_error one-cycle pulse when a stop bit reads low
//   overflow      sticky; a good byte was dropped on a full buffer
interface uart_rx_if;
  logic [7:0] data;
  logic       data_valid;
  logic       data_ready;
  logic       framing_error;
  logic       overflow;
  modport master (output data, data_valid, framing_error, overflow, input data_ready);
  modport slave  (input data, data_valid, framing_error, overflow, output data_ready);
endinterface

// File: rtl/uart_rx.sv
// uart_rx: oversampling 8N1 UART receiver with stop-bit check and byte FIFO.
//   mclk      system clock
//   reset     synchronous, active-low
//   baud_x16  one-cycle tick at OVERSAMPLE x baud
//   serial    asynchronous line, idles high
//   rx        byte stream, framing_error and overflow (uart_rx_if master)
module uart_rx #(
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic      mclk,
  input  logic      reset,
  input  logic      baud_x16,
  input  logic      serial,
  uart_rx_if.master rx
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [TW-1:0] MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] LAST = TW'(OVERSAMPLE - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
  state_t        state, state_n;
  logic          sync_meta, line;
  logic [TW-1:0] tick_cnt, tick_n;
  logic [2:0]    bit_cnt, bit_n;
  logic [7:0]    shreg, shreg_n;
  logic          push, ferr;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          ferr_q, ovf_q;
  logic          dv, full, pop, wr;
  always_ff @(posedge mclk) begin
    if (!reset) begin
      sync_meta <= 1'b1;
      line      <= 1'b1;
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
    end else begin
      sync_meta <= serial;
      line      <= sync_meta;
      state     <= state_n;
      tick_cnt  <= tick_n;
      bit_cnt   <= bit_n;
      shreg     <= shreg_n;
    end
  end
  // Start detection counts from the first low tick, so the start-bit midpoint
  // is OVERSAMPLE/2 ticks later and each further bit midpoint OVERSAMPLE ticks on.
  always_comb begin
    state_n = state;
    tick_n  = tick_cnt;
    bit_n   = bit_cnt;
    shreg_n = shreg;
    push    = 1'b0;
    ferr    = 1'b0;
    if (baud_x16)
      case (state)
        IDLE: if (!line) begin
          state_n = START;
          tick_n  = '0;
        end
        START: if (tick_cnt == MID) begin
          state_n = line ? IDLE : DATA;
          tick_n  = '0;
          bit_n   = '0;
        end else tick_n = tick_cnt + 1'b1;
        DATA: if (tick_cnt == LAST) begin
          tick_n  = '0;
          shreg_n = {line, shreg[7:1]};
          bit_n   = bit_cnt + 3'd1;
          state_n = bit_cnt == 3'd7 ? STOP : DATA;
        end else tick_n = tick_cnt + 1'b1;
        STOP: if (tick_cnt == LAST) begin
          tick_n  = '0;
          state_n = line ? IDLE : WAIT_HIGH;
          push    = line;
          ferr    = !line;
        end else tick_n = tick_cnt + 1'b1;
        WAIT_HIGH: state_n = line ? IDLE : WAIT_HIGH;
        default: state_n = IDLE;
      endcase
  end
  assign dv   = count != '0;
  assign full = count == CW'(FIFO_DEPTH);
  assign pop  = dv && rx.data_ready;
  // A push into a full buffer only lands if the head leaves on the same edge.
  assign wr   = push && (!full || pop);
  always_ff @(posedge mclk)
    if (wr) mem[wr_ptr] <= shreg;
  always_ff @(posedge mclk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ferr_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count  <= count + CW'(wr) - CW'(pop);
      ferr_q <= ferr;
      if (push && !wr) ovf_q <= 1'b1;
    end
  end
  assign rx.data          = dv ? mem[rd_ptr] : 8'h00;
  assign rx.data_valid    = dv;
  assign rx.framing_error = ferr_q;
  assign rx.overflow      = ovf_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized scenario bench for uart_rx against a byte-level model.
module tb_uart_rx;
  localparam int OS = 16;
  localparam int DEPTH = 4;
  localparam int BIT = OS * 3;
  localparam int STOP_TICK = 1 + OS / 2 + 9 * OS;
  logic mclk = 1'b0;
  logic reset = 1'b0;
  logic baud_x16 = 1'b0;
  logic serial = 1'b1;
  int chk = 0, pass = 0;
  int ferr_cnt = 0, ferr_run = 0, ferr_max = 0, v_run = 0, v_max = 0;
  logic ferr_prev = 1'b0;
  logic [7:0] got[$];
  uart_rx_if rx();
  uart_rx #(.OVERSAMPLE(OS), .FIFO_DEPTH(DEPTH)) dut (
    .mclk(mclk), .reset(reset), .baud_x16(baud_x16), .serial(serial), .rx(rx)
  );
  always #10 mclk = ~mclk;
  initial forever begin
    repeat (2) @(negedge mclk);
    baud_x16 = 1'b1;
    @(negedge mclk);
    baud_x16 = 1'b0;
  end
  initial forever begin
    @(negedge mclk);
    #3;
    if (rx.data_valid && rx.data_ready) got.push_back(rx.data);
    if (rx.framing_error && !ferr_prev) ferr_cnt++;
    ferr_run = rx.framing_error ? ferr_run + 1 : 0;
    if (ferr_run > ferr_max) ferr_max = ferr_run;
    v_run = rx.data_valid ? v_run + 1 : 0;
    if (v_run > v_max) v_max = v_run;
    ferr_prev = rx.framing_error;
  end
  task automatic do_reset();
    reset = 1'b0;
    serial = 1'b1;
    rx.data_ready = 1'b0;
    repeat (3) @(negedge mclk);
    reset = 1'b1;
    @(negedge mclk);
    got.delete();
    ferr_cnt = 0;
    ferr_max = 0;
    v_max = 0;
  endtask
  // Drives one 8N1 frame. With pulse_ready, data_ready is raised for exactly the
  // cycle whose edge takes the stop sample: two synchronizer edges after the
  // falling edge, then STOP_TICK ticks counted from the first low tick.
  task automatic send_frame(input logic [7:0] b, input logic stop, input bit pulse_ready);
    int n;
    @(negedge mclk);
    serial = 1'b0;
    fork
      begin
        repeat (BIT) @(negedge mclk);
        for (int i = 0; i < 8; i++) begin
          serial = b[i];
          repeat (BIT) @(negedge mclk);
        end
        serial = stop;
        repeat (BIT) @(negedge mclk);
      end
      begin
        if (pulse_ready) begin
          n = 0;
          repeat (2) @(negedge mclk);
          while (n < STOP_TICK) begin
            #1;
            if (baud_x16) n++;
            if (n < STOP_TICK) @(negedge mclk);
          end
          rx.data_ready = 1'b1;
          @(negedge mclk);
          #1;
          rx.data_ready = 1'b0;
        end
      end
    join
  endtask
  task automatic test_reset();
    rx.data_ready = 1'b0;
    serial = 1'b1;
    reset = 1'b0;
    repeat (3) @(negedge mclk);
    #3;
    chk++; if (rx.data !== 8'h00) $display("FAIL reset_data: got %h want 00", rx.data); else pass++;
    chk++; if (rx.data_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", rx.data_valid); else pass++;
    chk++; if (rx.framing_error !== 1'b0) $display("FAIL reset_ferr: got %b want 0", rx.framing_error); else pass++;
    chk++; if (rx.overflow !== 1'b0) $display("FAIL reset_ovf: got %b want 0", rx.overflow); else pass++;
    do_reset();
  endtask
  task automatic test_single();
    do_reset();
    rx.data_ready = 1'b1;
    send_frame(8'h55, 1'b1, 1'b0);
    repeat (BIT) @(negedge mclk);
    chk++; if (got.size() !== 1) $display("FAIL single_count: got %0d want 1", got.size()); else pass++;
    chk++; if (got.size() > 0 && got[0] !== 8'h55) $display("FAIL single_data: got %h want 55", got[0]); else pass++;
    chk++; if (v_max !== 1) $display("FAIL single_pulse: got %0d cycles want 1", v_max); else pass++;
    chk++; if (ferr_cnt !== 0) $display("FAIL single_ferr: got %0d want 0", ferr_cnt); else pass++;
  endtask
  task automatic test_random();
    logic [7:0] exp[$];
    int n;
    do_reset();
    rx.data_ready = 1'b1;
    n = $urandom_range(4, 7);
    for (int i = 0; i < n; i++) exp.push_back(8'($urandom));
    for (int i = 0; i < n; i++) send_frame(exp[i], 1'b1, 1'b0);
    repeat (BIT) @(negedge mclk);
    chk++; if (got.size() !== n) $display("FAIL rand_count: got %0d want %0d", got.size(), n); else pass++;
    for (int i = 0; i < n && i < got.size(); i++) begin
      chk++; if (got[i] !== exp[i]) $display("FAIL rand_byte%0d: got %h want %h", i, got[i], exp[i]); else pass++;
    end
    chk++; if (rx.overflow !== 1'b0) $display("FAIL rand_ovf: got %b want 0", rx.overflow); else pass++;
  endtask
  task automatic test_overflow();
    logic [7:0] held;
    do_reset();
    for (int i = 0; i < 4; i++) send_frame(8'h41 + 8'(i), 1'b1, 1'b0);
    repeat (4) @(negedge mclk);
    #3;
    chk++; if (rx.overflow !== 1'b0) $display("FAIL ovf_at_full: got %b want 0", rx.overflow); else pass++;
    send_frame(8'h45, 1'b1, 1'b0);
    repeat (4) @(negedge mclk);
    #3;
    chk++; if (rx.overflow !== 1'b1) $display("FAIL ovf_set: got %b want 1", rx.overflow); else pass++;
    held = rx.data;
    chk++; if (held !== 8'h41 || rx.data_valid !== 1'b1) $display("FAIL ovf_head: got %h/%b want 41/1", held, rx.data_valid); else pass++;
    repeat (5) @(negedge mclk);
    #3;
    chk++; if (rx.data !== 8'h41) $display("FAIL ovf_hold: got %h want 41", rx.data); else pass++;
    rx.data_ready = 1'b1;
    repeat (20) @(negedge mclk);
    #3;
    chk++; if (got.size() !== 4) $display("FAIL ovf_drain_count: got %0d want 4", got.size()); else pass++;
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      chk++; if (got[i] !== 8'h41 + 8'(i)) $display("FAIL ovf_drain%0d: got %h want %h", i, got[i], 8'h41 + 8'(i)); else pass++;
    end
    chk++; if (rx.data_valid !== 1'b0) $display("FAIL ovf_empty: got %b want 0", rx.data_valid); else pass++;
    chk++; if (rx.overflow !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", rx.overflow); else pass++;
    do_reset();
    #3;
    chk++; if (rx.overflow !== 1'b0) $display("FAIL ovf_reset: got %b want 0", rx.overflow); else pass++;
  endtask
  task automatic test_random_overflow();
    logic [7:0] exp[$];
    int n, keep;
    do_reset();
    n = $urandom_range(1, 6);
    for (int i = 0; i < n; i++) exp.push_back(8'($urandom));
    for (int i = 0; i < n; i++) send_frame(exp[i], 1'b1, 1'b0);
    repeat (4) @(negedge mclk);
    #3;
    keep = n < DEPTH ? n : DEPTH;
    chk++; if (rx.overflow !== (n > DEPTH)) $display("FAIL rovf_flag: got %b want %b (n=%0d)", rx.overflow, n > DEPTH, n); else pass++;
    rx.data_ready = 1'b1;
    repeat (20) @(negedge mclk);
    chk++; if (got.size() !== keep) $display("FAIL rovf_count: got %0d want %0d", got.size(), keep); else pass++;
    for (int i = 0; i < keep && i < got.size(); i++) begin
      chk++; if (got[i] !== exp[i]) $display("FAIL rovf_byte%0d: got %h want %h", i, got[i], exp[i]); else pass++;
    end
  endtask
  task automatic test_framing();
    do_reset();
    rx.data_ready = 1'b1;
    send_frame(8'hA3, 1'b0, 1'b0);
    repeat (20 * BIT) @(negedge mclk);
    chk++; if (got.size() !== 0) $display("FAIL ferr_nodata: got %0d bytes want 0", got.size()); else pass++;
    serial = 1'b1;
    repeat (2 * BIT) @(negedge mclk);
    send_frame(8'h0D, 1'b1, 1'b0);
    repeat (BIT) @(negedge mclk);
    chk++; if (ferr_cnt !== 1) $display("FAIL ferr_count: got %0d want 1", ferr_cnt); else pass++;
    chk++; if (ferr_max !== 1) $display("FAIL ferr_width: got %0d cycles want 1", ferr_max); else pass++;
    chk++; if (got.size() !== 1 || got[0] !== 8'h0D) $display("FAIL ferr_after: got %0d bytes want one 0D", got.size()); else pass++;
  endtask
  task automatic test_glitch();
    logic [7:0] b;
    do_reset();
    rx.data_ready = 1'b1;
    @(negedge mclk);
    serial = 1'b0;
    repeat (4 * 3) @(negedge mclk);
    serial = 1'b1;
    repeat (3 * BIT) @(negedge mclk);
    chk++; if (got.size() !== 0 || v_max !== 0) $display("FAIL glitch_data: got %0d bytes want 0", got.size()); else pass++;
    chk++; if (ferr_cnt !== 0) $display("FAIL glitch_ferr: got %0d want 0", ferr_cnt); else pass++;
    b = 8'($urandom);
    send_frame(b, 1'b1, 1'b0);
    repeat (BIT) @(negedge mclk);
    chk++; if (got.size() !== 1 || got[0] !== b) $display("FAIL glitch_next: got %0d bytes want one %h", got.size(), b); else pass++;
  endtask
  task automatic test_reset_mid();
    logic [7:0] b;
    do_reset();
    rx.data_ready = 1'b1;
    b = 8'h7E;
    @(negedge mclk);
    serial = 1'b0;
    repeat (BIT) @(negedge mclk);
    for (int i = 0; i < 4; i++) begin
      serial = b[i];
      repeat (BIT) @(negedge mclk);
    end
    serial = b[4];
    repeat (BIT / 2) @(negedge mclk);
    reset = 1'b0;
    @(negedge mclk);
    reset = 1'b1;
    serial = 1'b1;
    repeat (12 * BIT) @(negedge mclk);
    send_frame(8'h0A, 1'b1, 1'b0);
    repeat (BIT) @(negedge mclk);
    chk++; if (got.size() !== 1 || got[0] !== 8'h0A) $display("FAIL midreset_data: got %0d bytes want one 0A", got.size()); else pass++;
    chk++; if (rx.overflow !== 1'b0 || ferr_cnt !== 0) $display("FAIL midreset_flags: got ovf %b ferr %0d want 0 0", rx.overflow, ferr_cnt); else pass++;
  endtask
  task automatic test_full_pop();
    logic [7:0] exp[$];
    do_reset();
    for (int i = 0; i < DEPTH; i++) exp.push_back(8'($urandom));
    for (int i = 0; i < DEPTH; i++) send_frame(exp[i], 1'b1, 1'b0);
    send_frame(8'h31, 1'b1, 1'b1);
    exp.push_back(8'h31);
    repeat (4) @(negedge mclk);
    #3;
    chk++; if (rx.overflow !== 1'b0) $display("FAIL fullpop_ovf: got %b want 0", rx.overflow); else pass++;
    rx.data_ready = 1'b1;
    repeat (20) @(negedge mclk);
    chk++; if (got.size() !== DEPTH + 1) $display("FAIL fullpop_count: got %0d want %0d", got.size(), DEPTH + 1); else pass++;
    for (int i = 0; i <= DEPTH && i < got.size(); i++) begin
      chk++; if (got[i] !== exp[i]) $display("FAIL fullpop_byte%0d: got %h want %h", i, got[i], exp[i]); else pass++;
    end
  endtask
  initial begin
    rx.data_ready = 1'b0;
    test_reset();
    test_single();
    test_random();
    test_overflow();
    test_random_overflow();
    test_framing();
    test_glitch();
    test_reset_mid();
    test_full_pop();
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end
endmodule
